// File: rtl/sample_frame_counter.sv
// Oversampled UART frame timer: counts ticks within a bit and bits within a frame.
// Ports: clk, RST (sync, active-high), enable, Prescale, data_len, par_en, stop2 in;
//        edge_cnt, bit_cnt, samp_en, bit_done, frame_done, busy, cfg_err out.
module sample_frame_counter #(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               enable,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic [3:0]         data_len,
    input  logic               par_en,
    input  logic               stop2,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               samp_en,
    output logic               bit_done,
    output logic               frame_done,
    output logic               busy,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [PRESC_W-1:0] edge_n;
    logic [3:0]         bit_n;
    logic               cfg_err_n;
    logic               latch;

    logic [PRESC_W-1:0] p_q;
    logic [3:0]         len_q;
    logic               par_q;
    logic               stop2_q;

    logic [PRESC_W-1:0] half;
    logic [3:0]         frame_len;
    logic               illegal;

    // Config is judged on the live inputs at the latch edge.
    assign illegal = (Prescale < PRESC_W'(4)) || Prescale[0] ||
                     (data_len < 4'd5) || (data_len > 4'd8);

    assign half      = p_q >> 1;
    assign frame_len = 4'd1 + len_q + {3'b000, par_q} + (stop2_q ? 4'd2 : 4'd1);

    assign busy       = (state == COUNT);
    assign bit_done   = busy && (edge_cnt == p_q - PRESC_W'(1));
    assign frame_done = bit_done && (bit_cnt == frame_len - 4'd1);
    assign samp_en    = busy && ((edge_cnt == half - PRESC_W'(1)) ||
                                 (edge_cnt == half) ||
                                 (edge_cnt == half + PRESC_W'(1)));

    always_comb begin
        state_n   = state;
        edge_n    = edge_cnt;
        bit_n     = bit_cnt;
        cfg_err_n = 1'b0;
        latch     = 1'b0;
        unique case (state)
            IDLE: begin
                edge_n = '0;
                bit_n  = '0;
                if (enable) begin
                    latch = 1'b1;
                    if (illegal) begin
                        state_n   = HOLD;
                        cfg_err_n = 1'b1;
                    end else begin
                        state_n = COUNT;
                    end
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_n = IDLE;
                    edge_n  = '0;
                    bit_n   = '0;
                end else if (frame_done) begin
                    state_n = HOLD;
                    edge_n  = '0;
                    bit_n   = '0;
                end else if (bit_done) begin
                    edge_n = '0;
                    bit_n  = bit_cnt + 4'd1;
                end else begin
                    edge_n = edge_cnt + PRESC_W'(1);
                end
            end
            HOLD: begin
                edge_n = '0;
                bit_n  = '0;
                if (!enable) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                edge_n  = '0;
                bit_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            cfg_err  <= 1'b0;
            p_q      <= PRESC_W'(8);
            len_q    <= 4'd8;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
        end else begin
            state    <= state_n;
            edge_cnt <= edge_n;
            bit_cnt  <= bit_n;
            cfg_err  <= cfg_err_n;
            if (latch) begin
                p_q     <= Prescale;
                len_q   <= data_len;
                par_q   <= par_en;
                stop2_q <= stop2;
            end
        end
    end

endmodule

// File: tb/tb_sample_frame_counter.sv
// Directed bench for sample_frame_counter: vector table plus long-frame sequences.
// Drives inputs 1 time unit after each rising edge and samples there.
module tb_sample_frame_counter;

    logic       clk = 1'b0;
    logic       RST;
    logic       enable;
    logic [5:0] Prescale;
    logic [3:0] data_len;
    logic       par_en;
    logic       stop2;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       samp_en, bit_done, frame_done, busy, cfg_err;

    int nvec  = 0;
    int nfail = 0;

    sample_frame_counter #(.PRESC_W(6)) dut (
        .clk(clk), .RST(RST), .enable(enable), .Prescale(Prescale),
        .data_len(data_len), .par_en(par_en), .stop2(stop2),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .samp_en(samp_en),
        .bit_done(bit_done), .frame_done(frame_done), .busy(busy),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [5:0]  p;
        logic [3:0]  len;
        logic        par;
        logic        st2;
        logic [14:0] exp;
    } vec_t;

    function automatic logic [14:0] mk(input int e, input int b, input bit s,
                                       input bit bd, input bit fd,
                                       input bit bu, input bit c);
        return {6'(e), 4'(b), s, bd, fd, bu, c};
    endfunction

    function automatic logic [14:0] obs();
        return {edge_cnt, bit_cnt, samp_en, bit_done, frame_done, busy, cfg_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [14:0] got,
                       input logic [14:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got e=%0d b=%0d s%b bd%b fd%b bu%b c%b, want e=%0d b=%0d s%b bd%b fd%b bu%b c%b",
                     name, got[14:9], got[8:5], got[4], got[3], got[2], got[1], got[0],
                     exp[14:9], exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    // Run a full legal frame; optionally change Prescale/data_len mid-frame.
    task automatic run_frame(input string name, input int p, input int len,
                             input bit par, input bit st2, input int n,
                             input bit chg);
        int bd_cnt = 0;
        int bad = 0;
        RST = 0; enable = 1; Prescale = 6'(p); data_len = 4'(len);
        par_en = par; stop2 = st2;
        for (int c = 0; c < n * p; c++) begin
            int e, b;
            bit s, bd, fd;
            tick();
            if (chg && c == 20) begin
                Prescale = 6'd32;
                data_len = 4'd5;
                stop2 = ~st2;
            end
            e  = c % p;
            b  = c / p;
            s  = (e >= p / 2 - 1) && (e <= p / 2 + 1);
            bd = (e == p - 1);
            fd = bd && (b == n - 1);
            if (bit_done) bd_cnt++;
            if (obs() !== mk(e, b, s, bd, fd, 1, 0)) begin
                if (bad < 3)
                    chk($sformatf("%s c%0d", name, c + 1), obs(), mk(e, b, s, bd, fd, 1, 0));
                bad++;
            end
        end
        chk_int({name, " badcycles"}, bad, 0);
        chk_int({name, " bitdones"}, bd_cnt, n);
        tick();
        chk({name, " hold"}, obs(), mk(0, 0, 0, 0, 0, 0, 0));
        repeat (2) begin
            tick();
            chk({name, " hold en1"}, obs(), mk(0, 0, 0, 0, 0, 0, 0));
        end
        enable = 0;
        tick();
        chk({name, " idle"}, obs(), mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    vec_t tbl[19];

    initial begin
        RST = 1; enable = 0; Prescale = 6'd8; data_len = 4'd8;
        par_en = 0; stop2 = 0;

        tbl[0]  = '{1, 0, 8, 8, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{0, 1, 7, 8, 0, 0, mk(0, 0, 0, 0, 0, 0, 1)};
        tbl[2]  = '{0, 1, 7, 8, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{0, 0, 7, 8, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{0, 1, 2, 8, 0, 0, mk(0, 0, 0, 0, 0, 0, 1)};
        tbl[5]  = '{0, 0, 2, 8, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[6]  = '{0, 1, 8, 9, 0, 0, mk(0, 0, 0, 0, 0, 0, 1)};
        tbl[7]  = '{0, 0, 8, 9, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{0, 1, 4, 5, 0, 0, mk(0, 0, 0, 0, 0, 1, 0)};
        tbl[9]  = '{0, 1, 4, 5, 0, 0, mk(1, 0, 1, 0, 0, 1, 0)};
        tbl[10] = '{0, 1, 4, 5, 0, 0, mk(2, 0, 1, 0, 0, 1, 0)};
        tbl[11] = '{0, 1, 4, 5, 0, 0, mk(3, 0, 1, 1, 0, 1, 0)};
        tbl[12] = '{0, 1, 4, 5, 0, 0, mk(0, 1, 0, 0, 0, 1, 0)};
        tbl[13] = '{0, 0, 4, 5, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[14] = '{0, 1, 4, 5, 0, 0, mk(0, 0, 0, 0, 0, 1, 0)};
        tbl[15] = '{1, 1, 4, 5, 0, 0, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[16] = '{0, 1, 6, 6, 1, 1, mk(0, 0, 0, 0, 0, 1, 0)};
        tbl[17] = '{0, 1, 6, 6, 1, 1, mk(1, 0, 0, 0, 0, 1, 0)};
        tbl[18] = '{0, 0, 6, 6, 1, 1, mk(0, 0, 0, 0, 0, 0, 0)};

        for (int i = 0; i < 19; i++) begin
            RST = tbl[i].rst; enable = tbl[i].en; Prescale = tbl[i].p;
            data_len = tbl[i].len; par_en = tbl[i].par; stop2 = tbl[i].st2;
            tick();
            chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        run_frame("p8l8", 8, 8, 0, 0, 10, 0);
        run_frame("p16l7ps", 16, 7, 1, 1, 11, 0);
        run_frame("p8chg", 8, 8, 0, 0, 10, 1);

        // Abort at bit 4, edge 2.
        RST = 0; enable = 1; Prescale = 6'd8; data_len = 4'd8;
        par_en = 0; stop2 = 0;
        repeat (35) tick();
        chk("abort pre", obs(), mk(2, 4, 0, 0, 0, 1, 0));
        enable = 0;
        tick();
        chk("abort idle", obs(), mk(0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("abort stay", obs(), mk(0, 0, 0, 0, 0, 0, 0));
        enable = 1;
        tick();
        chk("abort restart", obs(), mk(0, 0, 0, 0, 0, 1, 0));
        enable = 0;
        tick();

        // Reset mid-frame at bit 6.
        enable = 1;
        repeat (49) tick();
        chk("rst pre", obs(), mk(0, 6, 0, 0, 0, 1, 0));
        RST = 1;
        tick();
        chk("rst mid", obs(), mk(0, 0, 0, 0, 0, 0, 0));
        RST = 0;
        tick();
        chk("rst restart", obs(), mk(0, 0, 0, 0, 0, 1, 0));
        tick();
        chk("rst run", obs(), mk(1, 0, 0, 0, 0, 1, 0));
        enable = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
